// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer and synchronous flush.
// Define EXMEM_SKID_PERF_EN to add saturating stall and bubble counters.
module exmem_skid_stage #(
   parameter int DATA_W = 32,
   parameter int WB_W   = 2,
   parameter int MEM_W  = 3,
   parameter int REG_W  = 5
`ifdef EXMEM_SKID_PERF_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   in_wb,
   input  logic [MEM_W-1:0]  in_mem,
   input  logic [DATA_W-1:0] in_brnch_dst,
   input  logic              in_zflag,
   input  logic [DATA_W-1:0] in_alu_out,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [REG_W-1:0]  in_wr_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   out_wb,
   output logic [MEM_W-1:0]  out_mem,
   output logic [DATA_W-1:0] out_brnch_dst,
   output logic              out_zflag,
   output logic [DATA_W-1:0] out_alu_out,
   output logic [DATA_W-1:0] out_rt,
   output logic [REG_W-1:0]  out_wr_dst
`ifdef EXMEM_SKID_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   localparam int BW = WB_W + MEM_W + 3 * DATA_W + 1 + REG_W;

   logic [BW-1:0]    w_in_bdl;
   logic [BW-1:0]    r_main;
   logic [BW-1:0]    r_skid;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic             r_in_ready;
   logic             w_accept;
   logic             w_consume;
   logic [WB_W-1:0]  w_wb;
   logic [MEM_W-1:0] w_mem;

   assign w_in_bdl = {in_wb, in_mem, in_brnch_dst, in_zflag,
                      in_alu_out, in_rt, in_wr_dst};

   assign w_accept  = in_valid & r_in_ready;
   assign w_consume = r_main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (r_skid_valid) begin
         // in_ready is low here, so nothing can be accepted
         if (w_consume) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end
      end else if (!r_main_valid || w_consume) begin
         r_main_valid <= w_accept;
         if (w_accept) r_main <= w_in_bdl;
      end else if (w_accept) begin
         r_skid       <= w_in_bdl;
         r_skid_valid <= 1'b1;
         r_in_ready   <= 1'b0;
      end
   end

   assign {w_wb, w_mem, out_brnch_dst, out_zflag,
           out_alu_out, out_rt, out_wr_dst} = r_main;

   // Bubbles must never carry live write-back or memory control
   assign out_wb    = r_main_valid ? w_wb  : '0;
   assign out_mem   = r_main_valid ? w_mem : '0;
   assign out_valid = r_main_valid;
   assign in_ready  = r_in_ready;

`ifdef EXMEM_SKID_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_main_valid && !out_ready && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (!r_main_valid && !(&r_bubble_cnt))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
